hv_timing_gen: RTL and testbench

- Parametrised successor to the fixed-timing arcade video generator.
- Produces H/V counters, blanking, active-low syncs, screen positions, a line-interrupt pulse and a blanked, registered RGB output from a single master clock gated by a pixel clock-enable.
- Adds run-time sync shift (latched per frame), a programmable interrupt line and a frame toggle.
- Sits between the game core (consumes HPOS/VPOS, drives RGB) and arcade_video.

---
 rtl/hv_timing_pkg.sv | 82 ++++++++
 rtl/hv_timing_gen_if.sv | 47 ++++
 rtl/hv_axis_counter.sv | 74 +++++++
 rtl/hv_timing_gen.sv | 114 +++++++++++
 tb/tb_hv_timing_gen.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hv_timing_pkg.sv
// Shared types, default timing and the signed-shift helper for the H/V timing generator.
package hv_timing_pkg;

  localparam int CNT_W_DEF = 9;
  localparam int RGB_W_DEF = 12;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  localparam int H_TOTAL_DEF      = 384;
  localparam int H_ACT_START_DEF  = 16;
  localparam int H_ACT_END_DEF    = 272;
  localparam int H_SYNC_START_DEF = 312;
  localparam int H_SYNC_END_DEF   = 343;
  localparam int V_TOTAL_DEF      = 263;
  localparam int V_ACT_START_DEF  = 16;
  localparam int V_ACT_END_DEF    = 208;
  localparam int V_SYNC_START_DEF = 236;
  localparam int V_SYNC_END_DEF   = 243;

  typedef enum logic [1:0] {
    HW_NINJAKUN,
    HW_RAIDERS5,
    HW_NOVA2001,
    HW_PKUNWAR
  } hw_type_e;

  typedef struct packed {
    int h_total;
    int h_act_start;
    int h_act_end;
    int h_sync_start;
    int h_sync_end;
    int v_total;
    int v_act_start;
    int v_act_end;
    int v_sync_start;
    int v_sync_end;
  } timing_t;

  localparam timing_t TIMING_DEF = '{
    h_total:      H_TOTAL_DEF,
    h_act_start:  H_ACT_START_DEF,
    h_act_end:    H_ACT_END_DEF,
    h_sync_start: H_SYNC_START_DEF,
    h_sync_end:   H_SYNC_END_DEF,
    v_total:      V_TOTAL_DEF,
    v_act_start:  V_ACT_START_DEF,
    v_act_end:    V_ACT_END_DEF,
    v_sync_start: V_SYNC_START_DEF,
    v_sync_end:   V_SYNC_END_DEF
  };

  // All four boards ship with identical raster timing.
  localparam timing_t TIMING_NINJAKUN = TIMING_DEF;
  localparam timing_t TIMING_RAIDERS5 = TIMING_DEF;
  localparam timing_t TIMING_NOVA2001 = TIMING_DEF;
  localparam timing_t TIMING_PKUNWAR  = TIMING_DEF;

  function automatic timing_t hw_timing(hw_type_e hw);
    timing_t t;
    case (hw)
      HW_NINJAKUN: t = TIMING_NINJAKUN;
      HW_RAIDERS5: t = TIMING_RAIDERS5;
      HW_NOVA2001: t = TIMING_NOVA2001;
      default:     t = TIMING_PKUNWAR;
    endcase
    return t;
  endfunction

  // Adds a sign-extended 4-bit shift to base and folds the result back into 0..total-1.
  function automatic int shift_mod(int base, logic signed [3:0] shift, int total);
    int s;
    s = base + int'(shift);
    if (s < 0) begin
      s = s + total;
    end else if (s >= total) begin
      s = s - total;
    end
    return s;
  endfunction

endpackage

// File: rtl/hv_timing_gen_if.sv
// Video timing bundle between the generator (master) and the game core / video sink (slave).
// With HV_FLIP_EN defined the bundle carries the FLIP request.
interface hv_timing_gen_if #(
  parameter int RGB_W = 12,
  parameter int CNT_W = 9
);

  logic                    CE_PIX;
  logic signed [3:0]       H_SHIFT;
  logic signed [3:0]       V_SHIFT;
  logic [CNT_W-1:0]        VINT_LINE;
  logic [RGB_W-1:0]        iRGB;
`ifdef HV_FLIP_EN
  logic                    FLIP;
`endif

  logic [CNT_W-1:0]        HPOS;
  logic [CNT_W-1:0]        VPOS;
  logic                    HBLK;
  logic                    VBLK;
  logic                    HSYN;
  logic                    VSYN;
  logic                    VINT;
  logic                    FRAME;
  logic [RGB_W-1:0]        oRGB;

`ifdef HV_FLIP_EN
  modport master (
    input  CE_PIX, H_SHIFT, V_SHIFT, VINT_LINE, iRGB, FLIP,
    output HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, VINT, FRAME, oRGB
  );
  modport slave (
    output CE_PIX, H_SHIFT, V_SHIFT, VINT_LINE, iRGB, FLIP,
    input  HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, VINT, FRAME, oRGB
  );
`else
  modport master (
    input  CE_PIX, H_SHIFT, V_SHIFT, VINT_LINE, iRGB,
    output HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, VINT, FRAME, oRGB
  );
  modport slave (
    output CE_PIX, H_SHIFT, V_SHIFT, VINT_LINE, iRGB,
    input  HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, VINT, FRAME, oRGB
  );
`endif

endinterface

// File: rtl/hv_axis_counter.sv
// One raster axis: wrapping counter plus registered blank and shifted active-low sync flags,
// all evaluated on the next count so they change together with the counter.
module hv_axis_counter
  import hv_timing_pkg::*;
#(
  parameter int CNT_W      = 9,
  parameter int TOTAL      = 384,
  parameter int ACT_START  = 16,
  parameter int ACT_END    = 272,
  parameter int SYNC_START = 312,
  parameter int SYNC_END   = 343
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv_i,
  input  logic signed [3:0] shift_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CNT_W-1:0]  cnt_nxt_o,
  output logic              wrap_o,
  output logic              blk_o,
  output logic              syn_n_o
);

  if (!(ACT_START < ACT_END && ACT_END <= TOTAL && TOTAL <= (1 << CNT_W))) begin : g_bad_cfg
    $fatal(1, "hv_axis_counter: illegal axis timing parameters");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blk_q, blk_d;
  logic             syn_n_q, syn_n_d;
  logic             wrap;
  int               nxt;
  int               sync_start;
  int               sync_end;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    cnt_d      = cnt_q;
    wrap       = adv_i && (int'(cnt_q) == TOTAL - 1);
    if (adv_i) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
    nxt        = int'(cnt_d);
    blk_d      = !(nxt >= ACT_START && nxt < ACT_END);
    sync_start = shift_mod(SYNC_START, shift_i, TOTAL);
    sync_end   = shift_mod(SYNC_END, shift_i, TOTAL);
    // A shifted window that crosses the wrap point is the union of its two ends.
    if (sync_start <= sync_end) begin
      syn_n_d = !(nxt >= sync_start && nxt < sync_end);
    end else begin
      syn_n_d = !(nxt >= sync_start || nxt < sync_end);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      blk_q   <= 1'b1;
      syn_n_q <= 1'b1;
    end else if (adv_i) begin
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      syn_n_q <= syn_n_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign wrap_o    = wrap;
  assign blk_o     = blk_q;
  assign syn_n_o   = syn_n_q;

endmodule

// File: rtl/hv_timing_gen.sv
// Parametrised arcade H/V timing generator: counters, blanks, shifted syncs, line IRQ,
// frame toggle and blanked registered RGB. Optional HV_FLIP_EN adds a per-frame FLIP input.
module hv_timing_gen
  import hv_timing_pkg::*;
#(
  parameter int RGB_W        = RGB_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACT_START  = H_ACT_START_DEF,
  parameter int H_ACT_END    = H_ACT_END_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_END   = H_SYNC_END_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACT_START  = V_ACT_START_DEF,
  parameter int V_ACT_END    = V_ACT_END_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_END   = V_SYNC_END_DEF
) (
  input  logic             MCLK,
  input  logic             RESET,
  hv_timing_gen_if.master  vid
);

  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] vcnt, vcnt_nxt;
  logic             h_wrap, v_wrap;
  logic             hblk, vblk, hsyn_n, vsyn_n;
  logic signed [3:0] hs_q, hs_d;
  logic signed [3:0] vs_q, vs_d;
  logic             vint_q, vint_d;
  logic             frame_q;
  logic [RGB_W-1:0] rgb_q;
`ifdef HV_FLIP_EN
  logic             flip_q, flip_d;
`endif

  hv_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(H_TOTAL), .ACT_START(H_ACT_START), .ACT_END(H_ACT_END),
    .SYNC_START(H_SYNC_START), .SYNC_END(H_SYNC_END)
  ) u_h (
    .clk(MCLK), .rst(RESET), .adv_i(vid.CE_PIX), .shift_i(hs_d),
    .cnt_o(hcnt), .cnt_nxt_o(hcnt_nxt), .wrap_o(h_wrap), .blk_o(hblk), .syn_n_o(hsyn_n)
  );

  hv_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(V_TOTAL), .ACT_START(V_ACT_START), .ACT_END(V_ACT_END),
    .SYNC_START(V_SYNC_START), .SYNC_END(V_SYNC_END)
  ) u_v (
    .clk(MCLK), .rst(RESET), .adv_i(h_wrap), .shift_i(vs_d),
    .cnt_o(vcnt), .cnt_nxt_o(vcnt_nxt), .wrap_o(v_wrap), .blk_o(vblk), .syn_n_o(vsyn_n)
  );

  // Frame-start values feed the sync compare directly, so the first pixel of a frame
  // already uses the newly latched shift.
  always_comb begin
    hs_d   = hs_q;
    vs_d   = vs_q;
`ifdef HV_FLIP_EN
    flip_d = flip_q;
`endif
    if (v_wrap) begin
      hs_d   = vid.H_SHIFT;
      vs_d   = vid.V_SHIFT;
`ifdef HV_FLIP_EN
      flip_d = vid.FLIP;
`endif
    end
    vint_d = vid.CE_PIX && (hcnt_nxt == '0) && (vcnt_nxt == vid.VINT_LINE);
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      hs_q    <= '0;
      vs_q    <= '0;
      vint_q  <= 1'b0;
      frame_q <= 1'b0;
      rgb_q   <= '0;
`ifdef HV_FLIP_EN
      flip_q  <= 1'b0;
`endif
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
`ifdef HV_FLIP_EN
      flip_q <= flip_d;
`endif
      // VINT is an MCLK-wide strobe, so it is not held by CE_PIX.
      vint_q <= vint_d;
      if (v_wrap) begin
        frame_q <= ~frame_q;
      end
      if (vid.CE_PIX) begin
        rgb_q <= (hblk || vblk) ? '0 : vid.iRGB;
      end
    end
  end

`ifdef HV_FLIP_EN
  assign vid.HPOS = flip_q ? CNT_W'(H_ACT_END - 1) - hcnt : hcnt - CNT_W'(H_ACT_START);
  assign vid.VPOS = flip_q ? CNT_W'(V_ACT_END - 1) - vcnt : vcnt - CNT_W'(V_ACT_START);
`else
  assign vid.HPOS = hcnt - CNT_W'(H_ACT_START);
  assign vid.VPOS = vcnt - CNT_W'(V_ACT_START);
`endif

  assign vid.HBLK  = hblk;
  assign vid.VBLK  = vblk;
  assign vid.HSYN  = hsyn_n;
  assign vid.VSYN  = vsyn_n;
  assign vid.VINT  = vint_q;
  assign vid.FRAME = frame_q;
  assign vid.oRGB  = rgb_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Directed bench: a default-timing instance for line-level behaviour and a small-raster
// instance for frame-level behaviour (shift latching, VINT, FRAME).
module tb_hv_timing_gen;
  import hv_timing_pkg::*;

  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  hv_timing_gen_if #(.RGB_W(12), .CNT_W(9)) vd ();
  hv_timing_gen_if #(.RGB_W(12), .CNT_W(9)) vs ();

  hv_timing_gen dut (
    .MCLK(mclk), .RESET(reset), .vid(vd)
  );

  hv_timing_gen #(
    .H_TOTAL(20), .H_ACT_START(2), .H_ACT_END(14), .H_SYNC_START(15), .H_SYNC_END(18),
    .V_TOTAL(10), .V_ACT_START(1), .V_ACT_END(7), .V_SYNC_START(8), .V_SYNC_END(9)
  ) dut_s (
    .MCLK(mclk), .RESET(reset), .vid(vs)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int kcnt     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic ce);
    vd.CE_PIX = ce;
    vs.CE_PIX = ce;
    @(posedge mclk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (kcnt < target) begin
      tick(1'b1);
      kcnt++;
    end
  endtask

  task automatic do_reset();
    vd.CE_PIX = 1'b0;
    vs.CE_PIX = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge mclk);
    #1;
    reset = 1'b0;
    kcnt = 0;
  endtask

  typedef struct {
    int         k;
    logic       hblk, vblk, hsyn;
    cnt_t       hpos, vpos;
    logic [11:0] orgb;
  } dvec_t;

  typedef enum logic [2:0] {S_SET, S_HSYN, S_VSYN, S_VBLK, S_FRAME, S_VINT} sel_e;
  typedef struct {
    int         k;
    sel_e       sel;
    logic [7:0] val;
  } svec_t;

  dvec_t dtab[$];
  svec_t stab[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hlow, blow, cyc, pulses;
    int h;

    reset = 1'b1;
    vd.CE_PIX = 1'b0; vd.H_SHIFT = 4'sd0; vd.V_SHIFT = 4'sd0; vd.VINT_LINE = 9'd208; vd.iRGB = 12'hFFF;
    vs.CE_PIX = 1'b0; vs.H_SHIFT = 4'sd0; vs.V_SHIFT = 4'sd0; vs.VINT_LINE = 9'd3;   vs.iRGB = 12'h000;

    // k = line*384 + hcnt after k enabled edges from reset.
    dtab.push_back('{15,   1, 1, 1, 9'd511, 9'd496, 12'h000});
    dtab.push_back('{16,   0, 1, 1, 9'd0,   9'd496, 12'h000});
    dtab.push_back('{271,  0, 1, 1, 9'd255, 9'd496, 12'h000});
    dtab.push_back('{272,  1, 1, 1, 9'd256, 9'd496, 12'h000});
    dtab.push_back('{311,  1, 1, 1, 9'd295, 9'd496, 12'h000});
    dtab.push_back('{312,  1, 1, 0, 9'd296, 9'd496, 12'h000});
    dtab.push_back('{342,  1, 1, 0, 9'd326, 9'd496, 12'h000});
    dtab.push_back('{343,  1, 1, 1, 9'd327, 9'd496, 12'h000});
    dtab.push_back('{384,  1, 1, 1, 9'd496, 9'd497, 12'h000});
    dtab.push_back('{6143, 1, 1, 1, 9'd367, 9'd511, 12'h000});
    dtab.push_back('{6144, 1, 0, 1, 9'd496, 9'd0,   12'h000});
    dtab.push_back('{6160, 0, 0, 1, 9'd0,   9'd0,   12'h000});
    dtab.push_back('{6161, 0, 0, 1, 9'd1,   9'd0,   12'hFFF});
    dtab.push_back('{6416, 1, 0, 1, 9'd256, 9'd0,   12'hFFF});
    dtab.push_back('{6417, 1, 0, 1, 9'd257, 9'd0,   12'h000});

    // Small raster: k = line*20 + hcnt, frame = 200 edges.
    stab.push_back('{19,  S_VBLK,  8'd1});
    stab.push_back('{20,  S_VBLK,  8'd0});
    stab.push_back('{50,  S_SET,   8'hC1});
    stab.push_back('{59,  S_VINT,  8'd0});
    stab.push_back('{60,  S_VINT,  8'd1});
    stab.push_back('{61,  S_VINT,  8'd0});
    stab.push_back('{71,  S_HSYN,  8'd1});
    stab.push_back('{75,  S_HSYN,  8'd0});
    stab.push_back('{139, S_VBLK,  8'd0});
    stab.push_back('{140, S_VBLK,  8'd1});
    stab.push_back('{165, S_VSYN,  8'd0});
    stab.push_back('{185, S_VSYN,  8'd1});
    stab.push_back('{199, S_FRAME, 8'd0});
    stab.push_back('{200, S_FRAME, 8'd1});
    stab.push_back('{211, S_HSYN,  8'd0});
    stab.push_back('{213, S_HSYN,  8'd0});
    stab.push_back('{214, S_HSYN,  8'd1});
    stab.push_back('{215, S_HSYN,  8'd1});
    stab.push_back('{365, S_VSYN,  8'd1});
    stab.push_back('{385, S_VSYN,  8'd0});
    stab.push_back('{390, S_SET,   8'h40});
    stab.push_back('{399, S_HSYN,  8'd1});
    stab.push_back('{400, S_HSYN,  8'd0});
    stab.push_back('{400, S_FRAME, 8'd0});
    stab.push_back('{401, S_HSYN,  8'd0});
    stab.push_back('{402, S_HSYN,  8'd1});
    stab.push_back('{419, S_HSYN,  8'd0});
    stab.push_back('{420, S_HSYN,  8'd0});

    // Reset state
    do_reset();
    check("rst.hblk",  vd.HBLK,  1'b1);
    check("rst.vblk",  vd.VBLK,  1'b1);
    check("rst.hsyn",  vd.HSYN,  1'b1);
    check("rst.vsyn",  vd.VSYN,  1'b1);
    check("rst.vint",  vd.VINT,  1'b0);
    check("rst.frame", vd.FRAME, 1'b0);
    check("rst.orgb",  vd.oRGB,  12'h000);
    check("rst.hpos",  vd.HPOS,  9'd496);
    check("rst.vpos",  vd.VPOS,  9'd496);

    // Line-level vectors on the default raster
    for (int i = 0; i < dtab.size(); i++) begin
      run_to(dtab[i].k);
      check($sformatf("dtab[%0d].hblk", i), vd.HBLK, dtab[i].hblk);
      check($sformatf("dtab[%0d].vblk", i), vd.VBLK, dtab[i].vblk);
      check($sformatf("dtab[%0d].hsyn", i), vd.HSYN, dtab[i].hsyn);
      check($sformatf("dtab[%0d].hpos", i), vd.HPOS, dtab[i].hpos);
      check($sformatf("dtab[%0d].vpos", i), vd.VPOS, dtab[i].vpos);
      check($sformatf("dtab[%0d].orgb", i), vd.oRGB, dtab[i].orgb);
    end

    // Full active line 17: blank/sync widths and RGB gating one pixel behind HPOS
    hlow = 0;
    blow = 0;
    for (int i = 0; i < 384; i++) begin
      run_to(17 * 384 + i);
      h = i;
      check($sformatf("line17[%0d].hblk", h), vd.HBLK, !(h >= 16 && h < 272));
      check($sformatf("line17[%0d].orgb", h), vd.oRGB, (h >= 17 && h <= 272) ? 12'hFFF : 12'h000);
      check($sformatf("line17[%0d].hpos", h), vd.HPOS, cnt_t'(h - 16));
      if (!vd.HSYN) hlow++;
      if (!vd.HBLK) blow++;
    end
    check("line17.hsyn_low_count", hlow, 31);
    check("line17.hblk_low_count", blow, 256);

    // Asynchronous reset mid-line at hcnt=200
    run_to(18 * 384 + 200);
    check("pre_rst.orgb",    vd.oRGB,  12'hFFF);
    check("pre_rst.hblk",    vd.HBLK,  1'b0);
    check("pre_rst.s_frame", vs.FRAME, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.hblk",    vd.HBLK,  1'b1);
    check("async_rst.vblk",    vd.VBLK,  1'b1);
    check("async_rst.orgb",    vd.oRGB,  12'h000);
    check("async_rst.hpos",    vd.HPOS,  9'd496);
    check("async_rst.vpos",    vd.VPOS,  9'd496);
    check("async_rst.s_frame", vs.FRAME, 1'b0);
    @(posedge mclk);
    #1;
    reset = 1'b0;
    kcnt = 0;
    run_to(5);
    check("post_rst.hpos",  vd.HPOS,  9'd501);
    check("post_rst.vpos",  vd.VPOS,  9'd496);
    check("post_rst.frame", vd.FRAME, 1'b0);

    // CE_PIX every 4th cycle: hold between enables, blank period scales by 4
    do_reset();
    tick(1'b1);
    check("ce4.hpos_after_en", vd.HPOS, 9'd497);
    for (int j = 0; j < 3; j++) begin
      tick(1'b0);
      check($sformatf("ce4.hold[%0d].hpos", j), vd.HPOS, 9'd497);
      check($sformatf("ce4.hold[%0d].hblk", j), vd.HBLK, 1'b1);
    end
    for (int p = 0; p < 14; p++) begin
      tick(1'b1);
      repeat (3) tick(1'b0);
    end
    check("ce4.hblk_before_16", vd.HBLK, 1'b1);
    tick(1'b1);
    check("ce4.hblk_at_16", vd.HBLK, 1'b0);
    check("ce4.hpos_at_16", vd.HPOS, 9'd0);
    cyc = 0;
    while (vd.HBLK == 1'b0 && cyc < 1200) begin
      if ((cyc % 4) == 3) tick(1'b1);
      else tick(1'b0);
      cyc++;
    end
    check("ce4.active_mclks", cyc, 1024);

    // Frame-level vectors on the small raster
    do_reset();
    for (int i = 0; i < stab.size(); i++) begin
      run_to(stab[i].k);
      case (stab[i].sel)
        S_SET: begin
          vs.H_SHIFT = stab[i].val[7:4];
          vs.V_SHIFT = stab[i].val[3:0];
        end
        S_HSYN:  check($sformatf("stab[%0d].hsyn", i),  vs.HSYN,  stab[i].val[0]);
        S_VSYN:  check($sformatf("stab[%0d].vsyn", i),  vs.VSYN,  stab[i].val[0]);
        S_VBLK:  check($sformatf("stab[%0d].vblk", i),  vs.VBLK,  stab[i].val[0]);
        S_FRAME: check($sformatf("stab[%0d].frame", i), vs.FRAME, stab[i].val[0]);
        default: check($sformatf("stab[%0d].vint", i),  vs.VINT,  stab[i].val[0]);
      endcase
    end

    // VINT: one pulse per frame at hcnt=0, vcnt=3
    run_to(600);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      run_to(601 + i);
      if (vs.VINT) begin
        pulses++;
        check("vint.hpos_at_pulse", vs.HPOS, 9'd510);
        check("vint.vpos_at_pulse", vs.VPOS, 9'd2);
      end
    end
    check("vint.pulses_line3", pulses, 1);

    // VINT_LINE beyond the raster never fires
    vs.VINT_LINE = 9'd10;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      run_to(801 + i);
      if (vs.VINT) pulses++;
    end
    check("vint.pulses_line10", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
